// File: rtl/asm_char_stream_if.sv
// Byte-in / strobe-out bundle between the UART receiver, the normaliser and the assembler.
// master drives received bytes and downstream ready; slave is the normaliser.
interface asm_char_stream_if;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        out_ready;
    logic        new_character;
    logic        new_line;
    logic [7:0]  incoming_character;
    logic [15:0] line_number;
    logic        file_done;
    logic        overflow_flag;

    modport master (
        output rx_valid, rx_data, out_ready,
        input  new_character, new_line, incoming_character, line_number, file_done, overflow_flag
    );

    modport slave (
        input  rx_valid, rx_data, out_ready,
        output new_character, new_line, incoming_character, line_number, file_done, overflow_flag
    );
endinterface

// File: rtl/asm_char_stream.sv
// Normalises raw UART bytes into a lowercase token stream (comments, blank lines and
// redundant whitespace removed), buffers it, and replays it as paced character/line strobes.
module asm_char_stream #(
    parameter int         FIFO_DEPTH   = 16,
    parameter logic [7:0] COMMENT_CHAR = 8'h23,
    parameter logic [7:0] EOF_CHAR     = 8'h04
) (
    input logic         clk_in,
    input logic         rst_in,
    asm_char_stream_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = 27;
    localparam logic [1:0] KIND_CHR = 2'd0;
    localparam logic [1:0] KIND_EOL = 2'd1;
    localparam logic [1:0] KIND_EOF = 2'd2;

    typedef enum logic [2:0] {LINE_START, IN_TOKEN, IN_COMMENT, EOF_WRITE, DONE} in_state_t;

    in_state_t   state_reg, state_next;
    logic        pending_sp_reg, pending_sp_next;
    logic        line_has_text_reg, line_has_text_next;
    logic [15:0] src_line_reg;
    logic        line_inc;

    logic        is_ws, is_lf, is_comment, is_eof, is_print, line_text;
    logic [7:0]  rx_char;

    logic        wr_en, wr_sp, wr_accept;
    logic [1:0]  wr_kind;
    logic [7:0]  wr_char;

    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr_reg, rd_ptr_reg;
    logic          fifo_empty, fifo_full, pop;
    logic [EW-1:0] head;
    logic [1:0]    head_kind;
    logic          head_sp;
    logic [7:0]    head_char;
    logic [15:0]   head_line;

    logic        new_character_reg, new_character_next;
    logic        new_line_reg, new_line_next;
    logic [7:0]  incoming_character_reg, incoming_character_next;
    logic [15:0] line_number_reg, line_number_next;
    logic        file_done_reg, file_done_next;
    logic        overflow_reg;
    logic        sp_sent_reg, sp_sent_next;

    always_comb begin
        is_ws      = (bus.rx_data == 8'h20) || (bus.rx_data == 8'h09);
        is_lf      = (bus.rx_data == 8'h0A);
        is_comment = (bus.rx_data == COMMENT_CHAR);
        is_eof     = (bus.rx_data == EOF_CHAR);
        is_print   = (bus.rx_data >= 8'h21) && (bus.rx_data <= 8'h7E) && !is_comment;
        rx_char    = ((bus.rx_data >= 8'h41) && (bus.rx_data <= 8'h5A)) ? bus.rx_data + 8'h20
                                                                         : bus.rx_data;
        // A comment that followed a token still owes that line its EOL.
        line_text  = (state_reg == IN_TOKEN) || ((state_reg == IN_COMMENT) && line_has_text_reg);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_reg         <= LINE_START;
            pending_sp_reg    <= 1'b0;
            line_has_text_reg <= 1'b0;
            src_line_reg      <= 16'd1;
        end else begin
            state_reg         <= state_next;
            pending_sp_reg    <= pending_sp_next;
            line_has_text_reg <= line_has_text_next;
            if (line_inc)
                src_line_reg <= src_line_reg + 16'd1;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (state_reg == EOF_WRITE) begin
            state_next = DONE;
        end else if (bus.rx_valid && (state_reg != DONE)) begin
            if (is_eof)
                state_next = line_text ? EOF_WRITE : DONE;
            else if (is_lf)
                state_next = LINE_START;
            else if (is_comment && (state_reg != IN_COMMENT))
                state_next = IN_COMMENT;
            else if (is_print && (state_reg == LINE_START))
                state_next = IN_TOKEN;
        end
    end

    always_comb begin
        wr_en              = 1'b0;
        wr_kind            = KIND_CHR;
        wr_sp              = 1'b0;
        wr_char            = rx_char;
        line_inc           = 1'b0;
        pending_sp_next    = pending_sp_reg;
        line_has_text_next = line_has_text_reg;
        if (state_reg == EOF_WRITE) begin
            wr_en   = 1'b1;
            wr_kind = KIND_EOF;
        end else if (bus.rx_valid && (state_reg != DONE)) begin
            if (is_eof) begin
                wr_en   = 1'b1;
                wr_kind = line_text ? KIND_EOL : KIND_EOF;
            end else if (is_lf) begin
                wr_en              = line_text;
                wr_kind            = KIND_EOL;
                line_inc           = 1'b1;
                pending_sp_next    = 1'b0;
                line_has_text_next = 1'b0;
            end else if (state_reg != IN_COMMENT) begin
                if (is_comment) begin
                    line_has_text_next = (state_reg == IN_TOKEN);
                    pending_sp_next    = 1'b0;
                end else if (is_ws) begin
                    if (state_reg == IN_TOKEN)
                        pending_sp_next = 1'b1;
                end else if (is_print) begin
                    wr_en           = 1'b1;
                    wr_sp           = pending_sp_reg && (state_reg == IN_TOKEN);
                    pending_sp_next = 1'b0;
                end
            end
        end
    end

    // Head is read combinationally so a strobe can follow a write by a single cycle.
    always_comb begin
        fifo_empty = (wr_ptr_reg == rd_ptr_reg);
        fifo_full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
        wr_accept  = wr_en && (!fifo_full || pop);
        head       = mem[rd_ptr_reg[AW-1:0]];
        head_kind  = head[26:25];
        head_sp    = head[24];
        head_char  = head[23:16];
        head_line  = head[15:0];
    end

    always_ff @(posedge clk_in) begin
        if (wr_accept)
            mem[wr_ptr_reg[AW-1:0]] <= {wr_kind, wr_sp, wr_char, src_line_reg};
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (wr_accept)
                wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
            if (wr_en && !wr_accept)
                overflow_reg <= 1'b1;
        end
    end

    // A spaced token is split in two strobes; the entry stays at the head until the second.
    always_comb begin
        new_character_next      = 1'b0;
        new_line_next           = 1'b0;
        incoming_character_next = incoming_character_reg;
        line_number_next        = line_number_reg;
        file_done_next          = file_done_reg;
        sp_sent_next            = sp_sent_reg;
        pop                     = 1'b0;
        if (bus.out_ready && !fifo_empty) begin
            case (head_kind)
                KIND_CHR: begin
                    new_character_next = 1'b1;
                    line_number_next   = head_line;
                    if (head_sp && !sp_sent_reg) begin
                        incoming_character_next = 8'h20;
                        sp_sent_next            = 1'b1;
                    end else begin
                        incoming_character_next = head_char;
                        sp_sent_next            = 1'b0;
                        pop                     = 1'b1;
                    end
                end
                KIND_EOL: begin
                    new_line_next    = 1'b1;
                    line_number_next = head_line;
                    pop              = 1'b1;
                end
                default: begin
                    file_done_next = 1'b1;
                    pop            = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            new_character_reg      <= 1'b0;
            new_line_reg           <= 1'b0;
            incoming_character_reg <= 8'h00;
            line_number_reg        <= 16'd1;
            file_done_reg          <= 1'b0;
            sp_sent_reg            <= 1'b0;
        end else begin
            new_character_reg      <= new_character_next;
            new_line_reg           <= new_line_next;
            incoming_character_reg <= incoming_character_next;
            line_number_reg        <= line_number_next;
            file_done_reg          <= file_done_next;
            sp_sent_reg            <= sp_sent_next;
        end
    end

    assign bus.new_character      = new_character_reg;
    assign bus.new_line           = new_line_reg;
    assign bus.incoming_character = incoming_character_reg;
    assign bus.line_number        = line_number_reg;
    assign bus.file_done          = file_done_reg;
    assign bus.overflow_flag      = overflow_reg;
endmodule

// File: tb/tb_asm_char_stream.sv
// Directed bench for asm_char_stream: a table of source snippets with their expected
// strobe streams, plus hand-written overflow, pacing and mid-line reset sequences.
module tb_asm_char_stream;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    asm_char_stream_if bus_if ();

    asm_char_stream #(
        .FIFO_DEPTH  (4),
        .COMMENT_CHAR(8'h23),
        .EOF_CHAR    (8'h04)
    ) u_dut (
        .clk_in(clk),
        .rst_in(rst),
        .bus   (bus_if)
    );

    typedef struct {
        bit          nc;
        bit          nl;
        bit          rdy;
        logic [7:0]  ch;
        logic [15:0] ln;
    } ev_t;

    typedef struct {
        string name;
        string stim;
        bit    eot;
        string after;
        string exp;
        int    exp_line;
        bit    exp_done;
    } vec_t;

    ev_t  evq[$];
    vec_t vecs[6];
    logic rdy_at_edge = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   mark   = 0;

    always @(posedge clk) rdy_at_edge <= bus_if.out_ready;

    always @(negedge clk) begin
        if (bus_if.new_character || bus_if.new_line)
            evq.push_back('{bus_if.new_character, bus_if.new_line, rdy_at_edge,
                            bus_if.incoming_character, bus_if.line_number});
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus_if.rx_valid = 1'b1;
        bus_if.rx_data  = b;
        @(negedge clk);
        bus_if.rx_valid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++)
            send_byte(s[i]);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst             = 1'b1;
        bus_if.rx_valid = 1'b0;
        @(negedge clk);
        rst  = 1'b0;
        mark = evq.size();
    endtask

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            $display("ok   %s = %0h", name, act);
        end
    endtask

    task automatic check_events(input string name, input string exp, input int exp_line);
        int         n;
        ev_t        ev;
        logic [7:0] e;
        logic [7:0] ech;
        bit         is_nl;
        n = evq.size() - mark;
        check_val({name, " strobe count"}, n, exp.len());
        for (int i = 0; i < n && i < exp.len(); i++) begin
            ev    = evq[mark + i];
            e     = exp[i];
            is_nl = (e == 8'h0A);
            ech   = e;
            if (is_nl)
                ech = (i > 0) ? exp[i-1] : 8'h00;
            checks++;
            if (ev.nl != is_nl || ev.nc == is_nl || ev.ch != ech ||
                ev.ln != 16'(exp_line) || !ev.rdy) begin
                errors++;
                $display("FAIL %s ev%0d: got nc=%0b nl=%0b ch=%02h line=%0d rdy=%0b, expected nl=%0b ch=%02h line=%0d",
                         name, i, ev.nc, ev.nl, ev.ch, ev.ln, ev.rdy, is_nl, ech, exp_line);
            end else begin
                $display("ok   %s ev%0d nc=%0b nl=%0b ch=%02h line=%0d",
                         name, i, ev.nc, ev.nl, ev.ch, ev.ln);
            end
        end
        mark = evq.size();
    endtask

    initial begin
        vecs[0] = '{"basic",   "ADD x1, x2\n",                 1'b0, "",      "add x1, x2\n",  1, 1'b0};
        vecs[1] = '{"blanks",  "\r\n   \n# hi\nli a0 5 # c\n", 1'b0, "",      "li a0 5\n",     4, 1'b0};
        vecs[2] = '{"wsrun",   "  sub\t\t x3\n",               1'b0, "",      "sub x3\n",      1, 1'b0};
        vecs[3] = '{"eotline", "nop",                          1'b1, "zz\n",  "nop\n",         1, 1'b1};
        vecs[4] = '{"eotblank","x\n",                          1'b1, "q\n",   "x\n",           1, 1'b1};
        vecs[5] = '{"case",    "\tLW  T0,8(SP)\n",             1'b0, "",      "lw t0,8(sp)\n", 1, 1'b0};

        rst              = 1'b1;
        bus_if.rx_valid  = 1'b0;
        bus_if.rx_data   = 8'h00;
        bus_if.out_ready = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(1);
        check_val("reset new_character", bus_if.new_character, 0);
        check_val("reset new_line", bus_if.new_line, 0);
        check_val("reset incoming_character", bus_if.incoming_character, 0);
        check_val("reset line_number", bus_if.line_number, 1);
        check_val("reset file_done", bus_if.file_done, 0);
        check_val("reset overflow_flag", bus_if.overflow_flag, 0);

        for (int v = 0; v < 6; v++) begin
            do_reset();
            bus_if.out_ready = 1'b1;
            send_str(vecs[v].stim);
            if (vecs[v].eot)
                send_byte(8'h04);
            send_str(vecs[v].after);
            tick(30);
            check_events(vecs[v].name, vecs[v].exp, vecs[v].exp_line);
            check_val({vecs[v].name, " file_done"}, bus_if.file_done, vecs[v].exp_done);
            check_val({vecs[v].name, " overflow_flag"}, bus_if.overflow_flag, 0);
        end

        // Ready toggling: the space and the char of a spaced token land in separate ready cycles.
        do_reset();
        bus_if.out_ready = 1'b0;
        send_str("a b\n");
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            bus_if.out_ready = i[0];
        end
        bus_if.out_ready = 1'b1;
        tick(10);
        check_events("pacing", "a b\n", 1);

        // Overflow: four entries fit, e, f and the EOL are lost.
        do_reset();
        bus_if.out_ready = 1'b0;
        send_str("abcdef\n");
        tick(2);
        check_val("ovf flag", bus_if.overflow_flag, 1);
        check_val("ovf held strobes", evq.size() - mark, 0);
        bus_if.out_ready = 1'b1;
        tick(20);
        check_events("ovf drain", "abcd", 1);
        check_val("ovf flag sticky", bus_if.overflow_flag, 1);

        // Reset with three entries queued mid-line on source line 2.
        bus_if.out_ready = 1'b0;
        send_str("abc");
        @(negedge clk);
        rst              = 1'b1;
        bus_if.out_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_val("midrst new_character", bus_if.new_character, 0);
        check_val("midrst new_line", bus_if.new_line, 0);
        check_val("midrst file_done", bus_if.file_done, 0);
        check_val("midrst overflow_flag", bus_if.overflow_flag, 0);
        check_val("midrst line_number", bus_if.line_number, 1);
        mark = evq.size();
        tick(10);
        check_events("midrst flushed", "", 1);
        send_str("j x\n");
        tick(20);
        check_events("midrst reparse", "j x\n", 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
